// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and constants for the register-bank scheduler
package reg_bank_pkg;

  localparam int AW_DEF   = 2;
  localparam int NREG_DEF = 1 << AW_DEF;
  localparam int DW       = 8;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant; pointer moves past the owner on advance
module rr_arbiter2
  import reg_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       advance_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d     = advance ? ~advance_id : ptr_q;
    gnt_valid = |req;
    if (req[M_CPU] && req[M_DBG]) begin
      gnt_id = ptr_q;
    end else begin
      gnt_id = req[M_DBG] ? M_DBG : M_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= M_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_bank_scheduler.sv
// rtl/reg_bank_scheduler.sv - sequences a dual-read/single-write register bank for two masters
module reg_bank_scheduler
  import reg_bank_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int NREG = 1 << AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_rd1_en,
  input  logic            m0_rd2_en,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_rd1_addr,
  input  logic [AW-1:0]   m0_rd2_addr,
  input  logic [AW-1:0]   m0_wr_addr,
  input  logic [DW-1:0]   m0_wr_data,
  output logic            m0_gnt,
  output logic            m0_done,
  input  logic            m1_req,
  input  logic            m1_rd1_en,
  input  logic            m1_rd2_en,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_rd1_addr,
  input  logic [AW-1:0]   m1_rd2_addr,
  input  logic [AW-1:0]   m1_wr_addr,
  input  logic [DW-1:0]   m1_wr_data,
  output logic            m1_gnt,
  output logic            m1_done,
  output logic [DW-1:0]   rd1_data,
  output logic [DW-1:0]   rd2_data,
  output logic [NREG-1:0] load1_en,
  output logic [NREG-1:0] load2_en,
  output logic [NREG-1:0] save_en,
  output logic [DW-1:0]   save_byte,
  input  logic [DW-1:0]   bus1_in,
  input  logic [DW-1:0]   bus2_in
);

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  state_e          state_q, state_d;
  logic            own_q, own_d;
  logic            rd1_en_q, rd1_en_d;
  logic            rd2_en_q, rd2_en_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [NREG-1:0] load1_q, load1_d;
  logic [NREG-1:0] load2_q, load2_d;
  logic [NREG-1:0] save_q, save_d;
  logic [DW-1:0]   save_byte_q, save_byte_d;
  logic [DW-1:0]   rd1_data_q, rd1_data_d;
  logic [DW-1:0]   rd2_data_q, rd2_data_d;

  logic            arb_valid, arb_id, advance;
  logic            sel_rd1_en, sel_rd2_en, sel_we;
  logic [AW-1:0]   sel_rd1_addr, sel_rd2_addr, sel_wr_addr;
  logic [DW-1:0]   sel_wr_data;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst),
    .req        ({m1_req, m0_req}),
    .advance    (advance),
    .advance_id (own_q),
    .gnt_valid  (arb_valid),
    .gnt_id     (arb_id)
  );

  always_comb begin
    sel_rd1_en   = arb_id ? m1_rd1_en   : m0_rd1_en;
    sel_rd2_en   = arb_id ? m1_rd2_en   : m0_rd2_en;
    sel_we       = arb_id ? m1_we       : m0_we;
    sel_rd1_addr = arb_id ? m1_rd1_addr : m0_rd1_addr;
    sel_rd2_addr = arb_id ? m1_rd2_addr : m0_rd2_addr;
    sel_wr_addr  = arb_id ? m1_wr_addr  : m0_wr_addr;
    sel_wr_data  = arb_id ? m1_wr_data  : m0_wr_data;
  end

  // Enables are registered on the grant edge so the bank samples them one edge
  // later and its buses are stable for the capture edge that ends CAPTURE.
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    rd1_en_d    = rd1_en_q;
    rd2_en_d    = rd2_en_q;
    gnt_d       = '0;
    done_d      = '0;
    load1_d     = '0;
    load2_d     = '0;
    save_d      = '0;
    save_byte_d = save_byte_q;
    rd1_data_d  = rd1_data_q;
    rd2_data_d  = rd2_data_q;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d[arb_id] = 1'b1;
          own_d         = arb_id;
          rd1_en_d      = sel_rd1_en;
          rd2_en_d      = sel_rd2_en;
          load1_d       = sel_rd1_en ? onehot(sel_rd1_addr) : '0;
          load2_d       = sel_rd2_en ? onehot(sel_rd2_addr) : '0;
          save_d        = sel_we     ? onehot(sel_wr_addr)  : '0;
          save_byte_d   = sel_wr_data;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (rd1_en_q) rd1_data_d = bus1_in;
        if (rd2_en_q) rd2_data_d = bus2_in;
        done_d[own_q] = 1'b1;
        advance       = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      own_q       <= M_CPU;
      rd1_en_q    <= 1'b0;
      rd2_en_q    <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      load1_q     <= '0;
      load2_q     <= '0;
      save_q      <= '0;
      save_byte_q <= '0;
      rd1_data_q  <= '0;
      rd2_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      rd1_en_q    <= rd1_en_d;
      rd2_en_q    <= rd2_en_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      load1_q     <= load1_d;
      load2_q     <= load2_d;
      save_q      <= save_d;
      save_byte_q <= save_byte_d;
      rd1_data_q  <= rd1_data_d;
      rd2_data_q  <= rd2_data_d;
    end
  end

  assign m0_gnt    = gnt_q[M_CPU];
  assign m1_gnt    = gnt_q[M_DBG];
  assign m0_done   = done_q[M_CPU];
  assign m1_done   = done_q[M_DBG];
  assign load1_en  = load1_q;
  assign load2_en  = load2_q;
  assign save_en   = save_q;
  assign save_byte = save_byte_q;
  assign rd1_data  = rd1_data_q;
  assign rd2_data  = rd2_data_q;

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// tb/tb_reg_bank_scheduler.sv - directed bench with a bank emulator and a transaction-level model
module tb_reg_bank_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       i_req[2];
  logic       i_rd1e[2];
  logic       i_rd2e[2];
  logic       i_we[2];
  logic [1:0] i_a1[2];
  logic [1:0] i_a2[2];
  logic [1:0] i_wa[2];
  logic [7:0] i_wd[2];

  logic [1:0] gnt_o, done_o;
  logic [7:0] rd1_data, rd2_data, save_byte;
  logic [3:0] load1_en, load2_en, save_en;
  logic [7:0] bus1, bus2;

  reg_bank_scheduler #(.AW(2), .NREG(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(i_req[0]), .m0_rd1_en(i_rd1e[0]), .m0_rd2_en(i_rd2e[0]), .m0_we(i_we[0]),
    .m0_rd1_addr(i_a1[0]), .m0_rd2_addr(i_a2[0]), .m0_wr_addr(i_wa[0]), .m0_wr_data(i_wd[0]),
    .m0_gnt(gnt_o[0]), .m0_done(done_o[0]),
    .m1_req(i_req[1]), .m1_rd1_en(i_rd1e[1]), .m1_rd2_en(i_rd2e[1]), .m1_we(i_we[1]),
    .m1_rd1_addr(i_a1[1]), .m1_rd2_addr(i_a2[1]), .m1_wr_addr(i_wa[1]), .m1_wr_data(i_wd[1]),
    .m1_gnt(gnt_o[1]), .m1_done(done_o[1]),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .load1_en(load1_en), .load2_en(load2_en), .save_en(save_en), .save_byte(save_byte),
    .bus1_in(bus1), .bus2_in(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank emulator: samples enables at the edge, drives the buses from that edge on.
  logic [7:0] bank[4];
  initial begin
    for (int i = 0; i < 4; i++) bank[i] = 8'h00;
    bus1 = 8'hEE;
    bus2 = 8'hEE;
  end
  always @(posedge clk) begin
    bus1 <= 8'hEE;
    bus2 <= 8'hEE;
    for (int i = 0; i < 4; i++) begin
      if (save_en[i])  bank[i] <= save_byte;
      if (load1_en[i]) bus1 <= bank[i];
      if (load2_en[i]) bus2 <= bank[i];
    end
  end

  // Transaction-level model: grant, then the bank edge, then completion.
  int         m_phase = 0;
  logic       m_ptr = 1'b0, m_own = 1'b0;
  logic       p_r1, p_r2, p_we;
  logic [1:0] p_a1, p_a2, p_wa;
  logic [7:0] p_wd, p_v1, p_v2;
  logic [7:0] mregs[4];
  logic [1:0] e_gnt = '0, e_done = '0;
  logic [3:0] e_l1 = '0, e_l2 = '0, e_sv = '0;
  logic [7:0] e_sb = '0, e_rd1 = '0, e_rd2 = '0;

  task automatic model_step();
    if (!rst) begin
      m_phase = 0; m_ptr = 1'b0;
      e_gnt = '0; e_done = '0; e_l1 = '0; e_l2 = '0; e_sv = '0;
      e_sb = '0; e_rd1 = '0; e_rd2 = '0;
    end else begin
      e_gnt = '0; e_done = '0; e_l1 = '0; e_l2 = '0; e_sv = '0;
      if (m_phase == 0) begin
        if (i_req[0] || i_req[1]) begin
          m_own = (i_req[0] && i_req[1]) ? m_ptr : i_req[1];
          p_r1 = i_rd1e[m_own]; p_r2 = i_rd2e[m_own]; p_we = i_we[m_own];
          p_a1 = i_a1[m_own];   p_a2 = i_a2[m_own];   p_wa = i_wa[m_own];
          p_wd = i_wd[m_own];
          e_gnt = 2'b01 << m_own;
          e_l1  = p_r1 ? (4'b0001 << p_a1) : 4'b0000;
          e_l2  = p_r2 ? (4'b0001 << p_a2) : 4'b0000;
          e_sv  = p_we ? (4'b0001 << p_wa) : 4'b0000;
          e_sb  = p_wd;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        p_v1 = mregs[p_a1];
        p_v2 = mregs[p_a2];
        if (p_we) mregs[p_wa] = p_wd;
        m_phase = 2;
      end else begin
        if (p_r1) e_rd1 = p_v1;
        if (p_r2) e_rd2 = p_v2;
        e_done  = 2'b01 << m_own;
        m_ptr   = ~m_own;
        m_phase = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("cyc_gnt",   {30'd0, gnt_o},  {30'd0, e_gnt});
        chk("cyc_done",  {30'd0, done_o}, {30'd0, e_done});
        chk("cyc_load1", {28'd0, load1_en}, {28'd0, e_l1});
        chk("cyc_load2", {28'd0, load2_en}, {28'd0, e_l2});
        chk("cyc_save",  {28'd0, save_en},  {28'd0, e_sv});
        chk("cyc_sbyte", {24'd0, save_byte}, {24'd0, e_sb});
        chk("cyc_rd1",   {24'd0, rd1_data}, {24'd0, e_rd1});
        chk("cyc_rd2",   {24'd0, rd2_data}, {24'd0, e_rd2});
      end
    end
  end

  task automatic clear_inputs(input int m);
    i_req[m] = 1'b0; i_rd1e[m] = 1'b0; i_rd2e[m] = 1'b0; i_we[m] = 1'b0;
    i_a1[m] = 2'd0; i_a2[m] = 2'd0; i_wa[m] = 2'd0; i_wd[m] = 8'h00;
  endtask

  task automatic run_cmd(input int m, input logic r1, input logic [1:0] a1,
                         input logic r2, input logic [1:0] a2,
                         input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         output int glat, output int dlat,
                         output logic [3:0] l1, output logic [3:0] sv,
                         output logic [7:0] r1d, output logic [7:0] r2d,
                         output logic [1:0] dn);
    @(negedge clk);
    i_rd1e[m] = r1; i_a1[m] = a1; i_rd2e[m] = r2; i_a2[m] = a2;
    i_we[m] = we; i_wa[m] = wa; i_wd[m] = wd; i_req[m] = 1'b1;
    glat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (gnt_o[m]) begin glat = i; break; end
    end
    l1 = load1_en; sv = save_en;
    i_req[m] = 1'b0; i_wd[m] = ~wd; i_wa[m] = ~wa; i_we[m] = ~we; i_rd1e[m] = ~r1;
    dlat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done_o[m]) begin dlat = i; break; end
    end
    r1d = rd1_data; r2d = rd2_data; dn = done_o;
    clear_inputs(m);
  endtask

  int         gl, dl, gcyc[$], gid[$];
  logic [3:0] l1, sv;
  logic [7:0] r1d, r2d;
  logic [1:0] dn;
  bit         seen;

  initial begin
    clear_inputs(0);
    clear_inputs(1);
    i_req[0] = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
      chk("rst_en", {20'd0, load1_en, load2_en, save_en}, 32'd0);
      chk("rst_rd", {16'd0, rd1_data, rd2_data}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_gnt", {31'd0, gnt_o[0]}, 32'd1);
    i_req[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = done_o[0];
    end
    chk("nop_done_seen", {31'd0, seen}, 32'd1);

    run_cmd(0, 0, 0, 0, 0, 1, 2'd2, 8'hA5, gl, dl, l1, sv, r1d, r2d, dn);
    chk("wr_gnt_lat", gl, 32'd1);
    chk("wr_done_lat", dl, 32'd2);
    chk("wr_save_en", {28'd0, sv}, 32'h4);
    run_cmd(0, 1, 2'd2, 0, 0, 0, 0, 8'h00, gl, dl, l1, sv, r1d, r2d, dn);
    chk("rd_load1", {28'd0, l1}, 32'h4);
    chk("rd_data_a5", {24'd0, r1d}, 32'hA5);

    run_cmd(1, 0, 0, 0, 0, 1, 2'd1, 8'h11, gl, dl, l1, sv, r1d, r2d, dn);
    run_cmd(1, 0, 0, 0, 0, 1, 2'd3, 8'h33, gl, dl, l1, sv, r1d, r2d, dn);
    run_cmd(1, 1, 2'd1, 1, 2'd3, 0, 0, 8'h00, gl, dl, l1, sv, r1d, r2d, dn);
    chk("dual_rd1", {24'd0, r1d}, 32'h11);
    chk("dual_rd2", {24'd0, r2d}, 32'h33);
    chk("dual_done", {30'd0, dn}, 32'h2);

    @(negedge clk);
    i_rd1e[0] = 1'b1; i_a1[0] = 2'd1; i_req[0] = 1'b1;
    i_rd2e[1] = 1'b1; i_a2[1] = 2'd3; i_req[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        gcyc.push_back(c);
        gid.push_back(gnt_o[1] ? 1 : 0);
      end
    end
    clear_inputs(0);
    clear_inputs(1);
    repeat (4) @(negedge clk);
    chk("cont_count", gid.size(), 32'd4);
    if (gid.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("cont_owner", gid[k], k % 2);
        chk("cont_cycle", gcyc[k], 1 + 3 * k);
      end
    end

    run_cmd(0, 0, 0, 0, 0, 1, 2'd0, 8'h10, gl, dl, l1, sv, r1d, r2d, dn);
    run_cmd(0, 1, 2'd0, 0, 0, 1, 2'd0, 8'h20, gl, dl, l1, sv, r1d, r2d, dn);
    chk("rdw_old", {24'd0, r1d}, 32'h10);
    run_cmd(0, 1, 2'd0, 0, 0, 0, 0, 8'h00, gl, dl, l1, sv, r1d, r2d, dn);
    chk("rdw_new", {24'd0, r1d}, 32'h20);

    @(negedge clk);
    i_we[0] = 1'b1; i_wa[0] = 2'd1; i_wd[0] = 8'h77; i_req[0] = 1'b1;
    @(negedge clk);
    chk("issue_gnt", {31'd0, gnt_o[0]}, 32'd1);
    chk("issue_save", {28'd0, save_en}, 32'h2);
    clear_inputs(0);
    #2 rst = 1'b0;
    #1;
    chk("async_clr_en", {20'd0, load1_en, load2_en, save_en}, 32'd0);
    chk("async_clr_gnt", {30'd0, gnt_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", {30'd0, done_o}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_gnt", {30'd0, gnt_o}, 32'd0);
    end
    run_cmd(0, 1, 2'd1, 0, 0, 0, 0, 8'h00, gl, dl, l1, sv, r1d, r2d, dn);
    chk("lost_write", {24'd0, r1d}, 32'h11);

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_scheduler.md
Name: reg_bank_scheduler

Overview:
- Sequences a bank of NREG 8-bit dual-read/single-write registers: drives one-hot read-port-1/read-port-2/save enables, the shared save byte, and captures the two tri-state read buses.
- Shares the bank between two requesters, master 0 (CPU decode) and master 1 (debug/monitor), with round-robin arbitration and a request/grant/done handshake.
- Sits between the control unit and the general-purpose register bank.

Parameters:
- AW, 2, register address width.
- NREG, 1<<AW, number of registers; always a power of two, so every address is in range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mX_req  in  1  request from master X (X=0,1); held high until mX_gnt.
- mX_rd1_en  in  1  master X wants read port 1.
- mX_rd2_en  in  1  master X wants read port 2.
- mX_we  in  1  master X wants a write.
- mX_rd1_addr  in  AW  read port 1 address.
- mX_rd2_addr  in  AW  read port 2 address.
- mX_wr_addr  in  AW  write address.
- mX_wr_data  in  8  write data.
- mX_gnt  out  1  one-cycle pulse; command latched this edge.
- mX_done  out  1  one-cycle pulse; rd_data valid, write committed.
- rd1_data  out  8  captured read port 1 value; holds until next capture.
- rd2_data  out  8  captured read port 2 value; holds until next capture.
- load1_en  out  NREG  one-hot read port 1 enable to the bank.
- load2_en  out  NREG  one-hot read port 2 enable to the bank.
- save_en  out  NREG  one-hot write enable to the bank.
- save_byte  out  8  write data to the bank.
- bus1_in  in  8  read port 1 tri-state bus.
- bus2_in  in  8  read port 2 tri-state bus.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, rr pointer = master 0 preferred. All gnt/done = 0, all enables = 0, save_byte = 0, rd1_data = rd2_data = 0.
- All outputs are registered.
- Bank timing: registers sample the enables at the clock edge and drive the buses from that edge on. Bus values are captured one cycle after the enables are issued.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both request: grant the master the rr pointer prefers.
  - On grant: pulse mX_gnt, latch {rd1_en, rd2_en, we, addrs, wr_data} and the owner id, go to ISSUE.
- ISSUE (one cycle):
  - load1_en = onehot(rd1_addr) if rd1_en, else 0.
  - load2_en = onehot(rd2_addr) if rd2_en, else 0.
  - save_en = onehot(wr_addr) if we, else 0.
  - save_byte = latched wr_data.
  - Go to CAPTURE.
  - All enables return to 0 in CAPTURE.
- CAPTURE (one cycle):
  - rd1_data <= bus1_in if rd1_en, else unchanged; same rule for rd2_data with bus2_in.
  - Pulse owner done.
  - rr pointer <= the other master.
  - Go to IDLE.
- Latency: req seen at edge N gives gnt at N+1, enables during N+1..N+2, done at N+3. Throughput is one transaction per 3 cycles.
- Read and write to the same address in one command: the read returns the OLD value, because the enable and the write share an edge.
- Both read ports on the same address are legal; both return the same value.
- A command with no rd/we bits set still completes gnt→done, with zero enables.
- req dropped before gnt: the request is simply not seen. After gnt the master may drop or change its inputs without affecting the transaction.
- req still high at done: treated as a new request in IDLE. rr then favours the other master if it is also requesting.
- The scheduler never drives more than one bit per enable vector.
- Reset mid-transaction (ISSUE or CAPTURE): enables clear immediately, with no done pulse. A write whose save_en edge has not occurred is lost.

Decomposition:
- Package reg_bank_pkg:
  - state enum {IDLE, ISSUE, CAPTURE}
  - AW and NREG defaults
  - master id constants M_CPU=0, M_DBG=1
  - data width constant DW=8
- One sub-module, rr_arbiter2: 2-input round-robin grant with pointer update on an accept strobe.
- Onehot decode is a local function.

Test Plan:
- Reset: hold rst=0 for 3 cycles with m0_req=1 → no gnt, all enables 0, rd data 0. Release → m0_gnt exactly 1 cycle later.
- Write then read: m0 we addr2 data 0xA5 → save_en=0b0100 for one cycle, m0_done at N+3. Then m0 rd1 addr2 → load1_en=0b0100, rd1_data=0xA5 at done.
- Dual read: regs 1=0x11, 3=0x33; m1 rd1 addr1, rd2 addr3 → rd1_data=0x11, rd2_data=0x33, m1_done pulses, m0 signals idle.
- Contention: m0_req and m1_req held continuously → grants alternate m0, m1, m0, m1, each 3 cycles apart, no starvation.
- Read-during-write: reg0=0x10; m0 rd1 addr0, we addr0 data 0x20 → rd1_data=0x10. Next read of addr0 → 0x20.
- Reset in ISSUE: assert rst=0 while save_en=0b0010 → enables drop asynchronously, no done. After release, an idle bench shows no spurious gnt.
